// File: rtl/bit_len_scan.sv
// Multi-beat highest/lowest set-bit finder: a per-segment encode feeds a segment combine,
// and the beat results are accumulated into one global index per operand.
module bit_len_scan #(
  parameter int DW = 256,
  parameter int SW = 16,
  parameter int NBEAT = 4,
  localparam int IW = $clog2(DW * NBEAT)
) (
  input  logic          clk_i,
  input  logic          arst_ni,
  input  logic          clr_i,
  input  logic          in_valid_i,
  output logic          in_ready_o,
  input  logic [DW-1:0] in_data_i,
  input  logic          in_last_i,
  input  logic          mode_i,
  output logic          out_valid_o,
  input  logic          out_ready_i,
  output logic [IW-1:0] idx_o,
  output logic          zero_o,
  output logic          ovf_o
);

  localparam int NSEG = DW / SW;
  localparam int LW   = $clog2(SW);
  localparam int SIW  = (NSEG > 1) ? $clog2(NSEG) : 1;
  localparam int BW   = $clog2(NBEAT + 1);

  logic en, accept, cur_mode;
  logic [BW-1:0] in_bcnt_q, in_bcnt_d;
  logic mode_lat_q, mode_lat_d;

  logic [NSEG-1:0] seg_nz;
  logic [LW-1:0]   seg_loc [NSEG];

  logic            s1_vld_q, s1_vld_d, s1_last_q, s1_last_d, s1_mode_q, s1_mode_d;
  logic [BW-1:0]   s1_tag_q, s1_tag_d;
  logic [NSEG-1:0] s1_nz_q, s1_nz_d;
  logic [LW-1:0]   s1_loc_q [NSEG];
  logic [LW-1:0]   s1_loc_d [NSEG];

  logic          beat_nz, ovf_beat, nxt_found, nxt_ovf;
  logic [SIW-1:0] seg_sel;
  logic [LW-1:0]  loc_sel;
  logic [IW-1:0]  cand, nxt_idx;

  logic          found_q, found_d, acc_ovf_q, acc_ovf_d;
  logic [IW-1:0] acc_idx_q, acc_idx_d;
  logic          out_valid_q, out_valid_d, zero_q, zero_d, ovf_q, ovf_d;
  logic [IW-1:0] idx_q, idx_d;

  assign en         = ~out_valid_q | out_ready_i;
  assign in_ready_o = en & ~clr_i;
  assign accept     = in_valid_i & in_ready_o;
  // The beat counter is zero only on the first beat of an operand, so it doubles as the first flag.
  assign cur_mode   = (in_bcnt_q == '0) ? mode_i : mode_lat_q;

  always_comb begin
    in_bcnt_d  = in_bcnt_q;
    mode_lat_d = mode_lat_q;
    if (clr_i) begin
      in_bcnt_d = '0;
    end else if (accept) begin
      mode_lat_d = cur_mode;
      if (in_last_i)                        in_bcnt_d = '0;
      else if (in_bcnt_q != BW'(NBEAT))     in_bcnt_d = in_bcnt_q + 1'b1;
    end
  end

  always_comb begin
    for (int s = 0; s < NSEG; s++) begin
      seg_nz[s]  = 1'b0;
      seg_loc[s] = '0;
      for (int b = 0; b < SW; b++) begin
        if (in_data_i[s*SW + b] && (!seg_nz[s] || !cur_mode)) begin
          seg_nz[s]  = 1'b1;
          seg_loc[s] = LW'(b);
        end
      end
    end
  end

  always_comb begin
    s1_vld_d  = s1_vld_q;
    s1_last_d = s1_last_q;
    s1_mode_d = s1_mode_q;
    s1_tag_d  = s1_tag_q;
    s1_nz_d   = s1_nz_q;
    s1_loc_d  = s1_loc_q;
    if (clr_i) begin
      s1_vld_d = 1'b0;
    end else if (en) begin
      s1_vld_d = accept;
      if (accept) begin
        s1_last_d = in_last_i;
        s1_mode_d = cur_mode;
        s1_tag_d  = in_bcnt_q;
        s1_nz_d   = seg_nz;
        s1_loc_d  = seg_loc;
      end
    end
  end

  // Ascending scan: MSB mode keeps the last hit, LSB mode keeps the first.
  always_comb begin
    beat_nz = 1'b0;
    seg_sel = '0;
    loc_sel = '0;
    for (int s = 0; s < NSEG; s++) begin
      if (s1_nz_q[s] && (!beat_nz || !s1_mode_q)) begin
        beat_nz = 1'b1;
        seg_sel = SIW'(s);
        loc_sel = s1_loc_q[s];
      end
    end
  end

  assign cand     = IW'(s1_tag_q) * IW'(DW) + IW'(seg_sel) * IW'(SW) + IW'(loc_sel);
  assign ovf_beat = (s1_tag_q >= BW'(NBEAT));

  always_comb begin
    nxt_found = found_q;
    nxt_idx   = acc_idx_q;
    nxt_ovf   = acc_ovf_q | ovf_beat;
    if (beat_nz && !ovf_beat && (!s1_mode_q || !found_q)) begin
      nxt_found = 1'b1;
      nxt_idx   = cand;
    end
  end

  always_comb begin
    found_d     = found_q;
    acc_idx_d   = acc_idx_q;
    acc_ovf_d   = acc_ovf_q;
    out_valid_d = out_valid_q;
    idx_d       = idx_q;
    zero_d      = zero_q;
    ovf_d       = ovf_q;
    if (clr_i) begin
      found_d     = 1'b0;
      acc_idx_d   = '0;
      acc_ovf_d   = 1'b0;
      out_valid_d = 1'b0;
    end else if (en) begin
      out_valid_d = 1'b0;
      if (s1_vld_q) begin
        if (s1_last_q) begin
          out_valid_d = 1'b1;
          idx_d       = nxt_found ? nxt_idx : '0;
          zero_d      = ~nxt_found;
          ovf_d       = nxt_ovf;
          found_d     = 1'b0;
          acc_idx_d   = '0;
          acc_ovf_d   = 1'b0;
        end else begin
          found_d   = nxt_found;
          acc_idx_d = nxt_idx;
          acc_ovf_d = nxt_ovf;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      in_bcnt_q   <= '0;
      mode_lat_q  <= 1'b0;
      s1_vld_q    <= 1'b0;
      s1_last_q   <= 1'b0;
      s1_mode_q   <= 1'b0;
      s1_tag_q    <= '0;
      s1_nz_q     <= '0;
      s1_loc_q    <= '{default: '0};
      found_q     <= 1'b0;
      acc_idx_q   <= '0;
      acc_ovf_q   <= 1'b0;
      out_valid_q <= 1'b0;
      idx_q       <= '0;
      zero_q      <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      in_bcnt_q   <= in_bcnt_d;
      mode_lat_q  <= mode_lat_d;
      s1_vld_q    <= s1_vld_d;
      s1_last_q   <= s1_last_d;
      s1_mode_q   <= s1_mode_d;
      s1_tag_q    <= s1_tag_d;
      s1_nz_q     <= s1_nz_d;
      s1_loc_q    <= s1_loc_d;
      found_q     <= found_d;
      acc_idx_q   <= acc_idx_d;
      acc_ovf_q   <= acc_ovf_d;
      out_valid_q <= out_valid_d;
      idx_q       <= idx_d;
      zero_q      <= zero_d;
      ovf_q       <= ovf_d;
    end
  end

  assign out_valid_o = out_valid_q;
  assign idx_o       = idx_q;
  assign zero_o      = zero_q;
  assign ovf_o       = ovf_q;

endmodule

// File: doc/bit_len_scan.md
Name: bit_len_scan

Overview:
- Parametrised most-significant / least-significant set-bit finder for wide multi-beat operands, such as scalars and exponents in the proof datapath.
- Each beat is split into SW-bit segments. A two-level priority encode runs in a pipeline, and the result is accumulated across up to NBEAT beats of one operand.
- Produces a global bit index plus zero and overflow flags.
- Uses valid/ready handshakes on both sides with full backpressure.

Parameters:
- DW, 256: beat data width; DW % SW == 0.
- SW, 16: segment width for the first-level encode; power of 2, 2..64.
- NBEAT, 4: maximum beats per operand; beat 0 is least significant.
- IW, $clog2(DW*NBEAT): index width, derived; not for override.

Ports:
- clk_i  in  1  clock
- arst_ni  in  1  reset, asynchronous, active-low
- clr_i  in  1  synchronous flush of pipeline and accumulator
- in_valid_i  in  1  beat valid
- in_ready_o  out  1  beat accepted when in_valid_i & in_ready_o
- in_data_i  in  DW  beat data
- in_last_i  in  1  final beat of operand
- mode_i  in  1  0 = highest set bit, 1 = lowest set bit; sampled on first beat of operand
- out_valid_o  out  1  result valid
- out_ready_i  in  1  result consumed when out_valid_o & out_ready_i
- idx_o  out  IW  global bit index
- zero_o  out  1  operand had no set bit; idx_o = 0
- ovf_o  out  1  operand exceeded NBEAT beats

Behaviour:
- Reset: all registers clear. out_valid_o=0, idx_o=0, zero_o=0, ovf_o=0. in_ready_o=1 after reset release.
- Advance enable: en = ~out_valid_o | out_ready_i.
  - in_ready_o = en & ~clr_i.
  - When en=0, every stage holds; outputs stay stable; no beat is lost.
- Stage 1 (captures an accepted beat):
  - For each of the DW/SW segments, register a nonzero flag and a local index.
  - Local index is the highest set bit in MSB mode, the lowest in LSB mode.
  - Also register last, mode and the beat-number tag.
- Stage 2 (runs when stage-1 valid & en):
  - Combine segments into the beat-local index: highest nonzero segment (MSB) or lowest nonzero segment (LSB).
  - Candidate = bcnt*DW + seg*SW + local.
- Accumulator (found flag, idx, bcnt):
  - MSB mode: any nonzero beat overwrites idx, because later beats are more significant.
  - LSB mode: only the first nonzero beat writes idx; later beats are ignored.
  - bcnt increments per beat and clears after a last beat.
- Mode is latched on the first beat of each operand. mode_i on later beats is ignored.
- Result output:
  - When the stage-2 beat has last=1, load idx_o, zero_o (= ~found), ovf_o and set out_valid_o.
  - The accumulator clears in the same cycle, so a back-to-back operand starts clean.
- Latency: last beat accepted in cycle T gives out_valid_o=1 in cycle T+2 when unstalled.
- Throughput: one beat per cycle.
- out_valid_o stays high, with idx_o/zero_o/ovf_o stable, until out_ready_i. It then drops in the next cycle unless a new result loads in the same cycle.
- Overflow: beat number >= NBEAT sets the sticky ovf flag for the operand. Data of those beats is ignored, bcnt saturates, and the operand still terminates on in_last_i.
- Single-beat operand (first=last) is legal.
- clr_i: next edge clears stage 1, stage 2, the accumulator and out_valid_o. Clear has priority over a simultaneous accept or output handshake.
- Asynchronous reset mid-operand discards the partial operand. The first beat after release starts a new operand.
- Arithmetic: all index math is unsigned, IW bits, with no wrap. The maximum is NBEAT*DW-1.

Test Plan:
- Single-beat operand, data=1<<200, mode 0, out_ready_i=1 -> out_valid_o at T+2, idx_o=200, zero_o=0, ovf_o=0.
- Single beat, bits 3 and 255 set -> mode 0 gives idx_o=255; mode 1 gives idx_o=3.
- Three beats 0x5, 0x0, 1<<17 (last) -> mode 0 gives idx_o=529; mode 1 gives idx_o=0. Toggling mode_i on beats 1 and 2 changes nothing.
- Two all-zero beats -> zero_o=1, idx_o=0. A back-to-back next operand with bit 9 gives idx_o=9, with no state carried over.
- out_ready_i=0 for 5 cycles with a result pending and the next operand offered -> in_ready_o=0, outputs held, second result correct after release; no duplicate or lost result.
- Six beats, bit 1000 set in beat 3 and bit 1 in beat 5 (last), mode 0 -> idx_o=1000, ovf_o=1.
- clr_i, or arst_ni low, mid-operand -> no output for the aborted operand; the next operand is correct.
